// File: rtl/i2c_pkg.sv
// Shared constants and types for the I2C slave bit-level front end.
package i2c_pkg;

    localparam int unsigned SLAVE_ADDR_W  = 7;
    localparam int unsigned BITS_PER_BYTE = 8;

    typedef logic [3:0] bit_cnt_t;

    localparam bit_cnt_t BIT_CNT_FULL = bit_cnt_t'(BITS_PER_BYTE);

endpackage

// File: rtl/i2c_bus_frontend_if.sv
// Pad and slave-FSM signals of the I2C front end. The slave modport is the front end's view,
// the master modport is the controlling FSM and pad side.
interface i2c_bus_frontend_if;
    import i2c_pkg::*;

    logic                     scl_in;
    logic                     sda_in;
    logic                     sda_oe;
    logic                     clear_start;
    logic                     clear_stop;
    logic                     clear_counter;
    logic                     in_enable;
    logic                     out_en;
    logic                     send_ack;
    logic [BITS_PER_BYTE-1:0] tx_data;
    logic                     start;
    logic                     stop;
    logic                     SCL_negedge;
    logic                     counted_8;
    logic                     addr_valid;
    logic                     ACK;
    logic [BITS_PER_BYTE-1:0] data_in;

    modport slave (
        input  scl_in, sda_in, clear_start, clear_stop, clear_counter, in_enable, out_en,
               send_ack, tx_data,
        output sda_oe, start, stop, SCL_negedge, counted_8, addr_valid, ACK, data_in
    );

    modport master (
        output scl_in, sda_in, clear_start, clear_stop, clear_counter, in_enable, out_en,
               send_ack, tx_data,
        input  sda_oe, start, stop, SCL_negedge, counted_8, addr_valid, ACK, data_in
    );

endinterface

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pad line, plus a delay flop for edge detection.
module i2c_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic                   dly_q;

    // Reset to 1 so an idle bus produces no spurious edges when reset is released.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= '1;
            dly_q   <= 1'b1;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], din};
            dly_q   <= chain_q[SYNC_STAGES-1];
        end
    end

    assign sync = chain_q[SYNC_STAGES-1];
    assign rise = sync & ~dly_q;
    assign fall = ~sync & dly_q;

endmodule

// File: rtl/i2c_bus_frontend.sv
// Bit-level I2C slave front end: START/STOP detection, bit counting, receive shifter,
// master ACK sampling and open-drain SDA drive for ACK and read data.
module i2c_bus_frontend
    import i2c_pkg::*;
#(
    parameter logic [SLAVE_ADDR_W-1:0] SLAVE_ADDR  = 7'h49,
    parameter int unsigned             SYNC_STAGES = 2
) (
    input logic               clock,
    input logic               reset_n,
    i2c_bus_frontend_if.slave bus
);

    logic scl_s, scl_rise, scl_fall;
    logic sda_s, sda_rise, sda_fall;

    i2c_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_scl_sync (
        .clock  (clock),
        .reset_n(reset_n),
        .din    (bus.scl_in),
        .sync   (scl_s),
        .rise   (scl_rise),
        .fall   (scl_fall)
    );

    i2c_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sda_sync (
        .clock  (clock),
        .reset_n(reset_n),
        .din    (bus.sda_in),
        .sync   (sda_s),
        .rise   (sda_rise),
        .fall   (sda_fall)
    );

    // SCL high on both the synchronised and delayed sample: high and not just risen.
    logic scl_high;
    logic start_det, stop_det;

    assign scl_high  = scl_s & ~scl_rise;
    assign start_det = sda_fall & scl_high;
    assign stop_det  = sda_rise & scl_high;

    logic                     start_q, start_d;
    logic                     stop_q, stop_d;
    logic                     negedge_q, negedge_d;
    logic                     ack_q, ack_d;
    logic                     sda_oe_q, sda_oe_d;
    bit_cnt_t                 bit_cnt_q, bit_cnt_d;
    logic [BITS_PER_BYTE-1:0] data_q, data_d;
    logic                     cnt_full;
    logic                     bit_active;

    assign cnt_full   = (bit_cnt_q == BIT_CNT_FULL);
    assign bit_active = bit_cnt_q < BIT_CNT_FULL;

    always_comb begin
        start_d   = start_q;
        stop_d    = stop_q;
        negedge_d = scl_fall;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        ack_d     = ack_q;
        sda_oe_d  = 1'b0;

        // Set has priority over clear so a condition arriving with the clear is not lost.
        if (bus.clear_start) start_d = 1'b0;
        if (start_det)       start_d = 1'b1;
        if (bus.clear_stop)  stop_d  = 1'b0;
        if (stop_det)        stop_d  = 1'b1;

        if (bus.clear_counter) begin
            bit_cnt_d = '0;
        end else if (scl_rise && (bus.in_enable || bus.out_en) && bit_active) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
        end

        if (scl_rise && bus.in_enable && bit_active) begin
            data_d = {data_q[BITS_PER_BYTE-2:0], sda_s};
        end

        if (scl_rise && cnt_full && !bus.in_enable && !bus.out_en) begin
            ack_d = ~sda_s;
        end

        if (start_det || stop_det) begin
            sda_oe_d = 1'b0;
        end else if (bus.send_ack) begin
            sda_oe_d = 1'b1;
        end else if (bus.out_en && bit_active) begin
            sda_oe_d = ~bus.tx_data[3'd7 - bit_cnt_q[2:0]];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            negedge_q <= 1'b0;
            ack_q     <= 1'b0;
            sda_oe_q  <= 1'b0;
            bit_cnt_q <= '0;
            data_q    <= '0;
        end else begin
            start_q   <= start_d;
            stop_q    <= stop_d;
            negedge_q <= negedge_d;
            ack_q     <= ack_d;
            sda_oe_q  <= sda_oe_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
        end
    end

    assign bus.start       = start_q;
    assign bus.stop        = stop_q;
    assign bus.SCL_negedge = negedge_q;
    assign bus.counted_8   = cnt_full;
    assign bus.ACK         = ack_q;
    assign bus.sda_oe      = sda_oe_q;
    assign bus.data_in     = data_q;
    assign bus.addr_valid  = (data_q[BITS_PER_BYTE-1:1] == SLAVE_ADDR);

endmodule

// File: tb/tb_i2c_bus_frontend.sv
// Directed bench for the I2C slave front end: framing conditions, shifting, ACK and SDA drive.
module tb_i2c_bus_frontend;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    i2c_bus_frontend_if bus ();

    i2c_bus_frontend #(
        .SLAVE_ADDR (7'h49),
        .SYNC_STAGES(2)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Each pad change is held long enough to clear the synchroniser and delay flop.
    task automatic set_scl(input logic v);
        @(negedge clock);
        bus.scl_in = v;
        repeat (4) @(negedge clock);
    endtask

    task automatic set_sda(input logic v);
        @(negedge clock);
        bus.sda_in = v;
        repeat (4) @(negedge clock);
    endtask

    task automatic clock_bit(input logic b);
        set_sda(b);
        set_scl(1'b1);
        set_scl(1'b0);
    endtask

    task automatic pulse_clear_counter();
        @(negedge clock);
        bus.clear_counter = 1'b1;
        @(negedge clock);
        bus.clear_counter = 1'b0;
    endtask

    task automatic test_reset();
        reset_n           = 1'b0;
        bus.scl_in        = 1'b1;
        bus.sda_in        = 1'b1;
        bus.clear_start   = 1'b0;
        bus.clear_stop    = 1'b0;
        bus.clear_counter = 1'b0;
        bus.in_enable     = 1'b0;
        bus.out_en        = 1'b0;
        bus.send_ack      = 1'b0;
        bus.tx_data       = 8'h00;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            n_checks++;
            if ({bus.start, bus.stop, bus.SCL_negedge} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_flags cycle %0d: got %b expected 000", k,
                         {bus.start, bus.stop, bus.SCL_negedge});
            end
        end
        n_checks++;
        if (bus.sda_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sda_oe: got %b expected 0", bus.sda_oe);
        end
        n_checks++;
        if (bus.data_in !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data_in: got %h expected 00", bus.data_in);
        end
        n_checks++;
        if ({bus.counted_8, bus.ACK, bus.addr_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_status: got %b expected 000",
                     {bus.counted_8, bus.ACK, bus.addr_valid});
        end
    endtask

    task automatic test_start();
        @(negedge clock);
        bus.sda_in = 1'b0;
        @(negedge clock);
        @(negedge clock);
        n_checks++;
        if (bus.start !== 1'b0) begin
            n_fail++;
            $display("FAIL start_early: got %b expected 0", bus.start);
        end
        @(negedge clock);
        n_checks++;
        if (bus.start !== 1'b1) begin
            n_fail++;
            $display("FAIL start_latency: got %b expected 1", bus.start);
        end
        n_checks++;
        if (bus.stop !== 1'b0) begin
            n_fail++;
            $display("FAIL start_no_stop: got %b expected 0", bus.stop);
        end
        bus.clear_start = 1'b1;
        @(negedge clock);
        bus.clear_start = 1'b0;
        n_checks++;
        if (bus.start !== 1'b0) begin
            n_fail++;
            $display("FAIL start_clear: got %b expected 0", bus.start);
        end
    endtask

    task automatic test_scl_negedge();
        logic [3:0] seen;
        @(negedge clock);
        bus.scl_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            seen[k] = bus.SCL_negedge;
        end
        n_checks++;
        if (seen !== 4'b0100) begin
            n_fail++;
            $display("FAIL scl_negedge_pulse: got %b expected 0100", seen);
        end
        n_checks++;
        if (bus.start !== 1'b0) begin
            n_fail++;
            $display("FAIL scl_fall_no_start: got %b expected 0", bus.start);
        end
    endtask

    task automatic test_shift(input logic [7:0] b, input logic exp_valid);
        set_scl(1'b0);
        pulse_clear_counter();
        n_checks++;
        if (bus.counted_8 !== 1'b0) begin
            n_fail++;
            $display("FAIL shift_cnt_clear: got %b expected 0", bus.counted_8);
        end
        bus.in_enable = 1'b1;
        for (int k = 0; k < 8; k++) clock_bit(b[7-k]);
        bus.in_enable = 1'b0;
        n_checks++;
        if (bus.data_in !== b) begin
            n_fail++;
            $display("FAIL shift_data_in: got %h expected %h", bus.data_in, b);
        end
        n_checks++;
        if (bus.counted_8 !== 1'b1) begin
            n_fail++;
            $display("FAIL shift_counted_8: got %b expected 1", bus.counted_8);
        end
        n_checks++;
        if (bus.addr_valid !== exp_valid) begin
            n_fail++;
            $display("FAIL shift_addr_valid %h: got %b expected %b", b, bus.addr_valid, exp_valid);
        end
    endtask

    task automatic test_ack();
        set_sda(1'b0);
        set_scl(1'b1);
        n_checks++;
        if (bus.ACK !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_low: got %b expected 1", bus.ACK);
        end
        set_scl(1'b0);
        set_sda(1'b1);
        set_scl(1'b1);
        n_checks++;
        if (bus.ACK !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_high: got %b expected 0", bus.ACK);
        end
        n_checks++;
        if (bus.data_in !== 8'h94) begin
            n_fail++;
            $display("FAIL ack_data_hold: got %h expected 94", bus.data_in);
        end
        set_scl(1'b0);
    endtask

    task automatic test_clear_counter();
        logic [7:0] b = 8'h3C;
        // Line clear_counter up with the cycle the synchronised SCL rise is seen.
        @(negedge clock);
        bus.scl_in = 1'b1;
        @(negedge clock);
        @(negedge clock);
        bus.clear_counter = 1'b1;
        bus.in_enable     = 1'b1;
        @(negedge clock);
        bus.clear_counter = 1'b0;
        bus.in_enable     = 1'b0;
        n_checks++;
        if (bus.counted_8 !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_vs_rise: got counted_8 %b expected 0", bus.counted_8);
        end
        n_checks++;
        if (bus.data_in !== 8'h94) begin
            n_fail++;
            $display("FAIL clear_vs_rise_data: got %h expected 94", bus.data_in);
        end
        repeat (3) @(negedge clock);
        set_scl(1'b0);
        bus.in_enable = 1'b1;
        for (int k = 0; k < 7; k++) clock_bit(b[7-k]);
        n_checks++;
        if (bus.counted_8 !== 1'b0) begin
            n_fail++;
            $display("FAIL cnt_after_7: got %b expected 0", bus.counted_8);
        end
        clock_bit(b[0]);
        bus.in_enable = 1'b0;
        n_checks++;
        if ({bus.counted_8, bus.data_in} !== {1'b1, 8'h3C}) begin
            n_fail++;
            $display("FAIL cnt_after_8: got %b/%h expected 1/3c", bus.counted_8, bus.data_in);
        end
    endtask

    task automatic test_tx();
        logic [7:0] exp_oe = 8'h5A;
        @(negedge clock);
        bus.clear_counter = 1'b1;
        bus.tx_data       = 8'hA5;
        @(negedge clock);
        bus.clear_counter = 1'b0;
        n_checks++;
        if (bus.sda_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_idle: got %b expected 0", bus.sda_oe);
        end
        bus.send_ack = 1'b1;
        @(negedge clock);
        n_checks++;
        if (bus.sda_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ack: got %b expected 1", bus.sda_oe);
        end
        bus.out_en = 1'b1;
        @(negedge clock);
        n_checks++;
        if (bus.sda_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_over_out_en: got %b expected 1", bus.sda_oe);
        end
        bus.send_ack = 1'b0;
        @(negedge clock);
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (bus.sda_oe !== exp_oe[7-k]) begin
                n_fail++;
                $display("FAIL tx_bit %0d: got %b expected %b", k, bus.sda_oe, exp_oe[7-k]);
            end
            set_scl(1'b1);
            set_scl(1'b0);
        end
        n_checks++;
        if ({bus.counted_8, bus.sda_oe} !== 2'b10) begin
            n_fail++;
            $display("FAIL tx_done: got %b expected 10", {bus.counted_8, bus.sda_oe});
        end
        bus.out_en = 1'b0;
    endtask

    task automatic test_stop();
        @(negedge clock);
        bus.clear_counter = 1'b1;
        bus.tx_data       = 8'h00;
        bus.out_en        = 1'b1;
        @(negedge clock);
        bus.clear_counter = 1'b0;
        set_sda(1'b0);
        set_scl(1'b1);
        @(negedge clock);
        bus.sda_in = 1'b1;
        @(negedge clock);
        @(negedge clock);
        n_checks++;
        if ({bus.stop, bus.sda_oe} !== 2'b01) begin
            n_fail++;
            $display("FAIL stop_before: got %b expected 01", {bus.stop, bus.sda_oe});
        end
        @(negedge clock);
        n_checks++;
        if ({bus.stop, bus.sda_oe, bus.start} !== 3'b100) begin
            n_fail++;
            $display("FAIL stop_release: got %b expected 100", {bus.stop, bus.sda_oe, bus.start});
        end
        bus.out_en     = 1'b0;
        bus.clear_stop = 1'b1;
        @(negedge clock);
        bus.clear_stop = 1'b0;
        n_checks++;
        if (bus.stop !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_clear: got %b expected 0", bus.stop);
        end
    endtask

    task automatic test_async_reset();
        set_scl(1'b0);
        @(negedge clock);
        bus.clear_counter = 1'b1;
        bus.out_en        = 1'b1;
        @(negedge clock);
        bus.clear_counter = 1'b0;
        @(negedge clock);
        n_checks++;
        if (bus.sda_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_drive: got %b expected 1", bus.sda_oe);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.sda_oe, bus.data_in} !== 9'h000) begin
            n_fail++;
            $display("FAIL async_reset: got %b/%h expected 0/00", bus.sda_oe, bus.data_in);
        end
        bus.out_en = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++;
        if (bus.sda_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_release: got %b expected 0", bus.sda_oe);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_scl_negedge();
        test_shift(8'h92, 1'b1);
        test_shift(8'h94, 1'b0);
        test_ack();
        test_clear_counter();
        test_tx();
        test_stop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
